adi2axis_pkt: RTL and testbench

AXI-Stream packet framer directly downstream of the ADI-to-AXIS converter, in the same AXIS clock domain. It consumes the converter's capture stream and splits each capture into packets of a programmable number of payload words. Each packet is prefixed with a header word (magic, start-of-capture flag, length, sequence number). Output is a registered AXIS master feeding the DMA.

---
 rtl/adi2axis_pkt.sv | 218 +++++++++++++++++++++
 tb/tb_adi2axis_pkt.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adi2axis_pkt.sv
// -----------------------------------------------------------------------------
// adi2axis_pkt
// Packet framer that sits directly behind the ADI-to-AXIS converter. It cuts
// each capture into packets of pkt_words payload beats. Every packet starts
// with a 64-bit header: {16'hADC0, soc, plen[14:0], seq[31:0]}.
// The output is a single registered AXIS slot feeding the DMA.
//
// Optional feature macro: ADI2AXIS_PKT_TRAILER_EN
//   When this macro is defined, every packet also ends with a trailer beat:
//   {16'hADCF, ended_by_tlast, payload_count[14:0], header_seq}.
//   That trailer beat carries TLAST instead of the last payload beat.
//
// Ports:
//   AXIS_ACLK, AXIS_ARESETN : clock and synchronous active-low reset
//   S_AXIS_*                : capture stream from the converter (slave)
//   M_AXIS_*                : framed packet stream to the DMA (master)
//   enable                  : permits new packets to start
//   pkt_words               : payload words per packet (0 is treated as 1),
//                             sampled when the header is emitted
//   seq_clr                 : one-cycle pulse that clears the sequence counter
//   busy                    : framer is not idle
//   seq                     : sequence number the next header will carry
// -----------------------------------------------------------------------------
module adi2axis_pkt #(
    parameter int C_AXIS_TDATA_NUM_BYTES = 8
) (
    input  logic                                AXIS_ACLK,
    input  logic                                AXIS_ARESETN,
    input  logic                                S_AXIS_TVALID,
    input  logic [8*C_AXIS_TDATA_NUM_BYTES-1:0] S_AXIS_TDATA,
    input  logic [C_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,
    output logic                                M_AXIS_TVALID,
    output logic [8*C_AXIS_TDATA_NUM_BYTES-1:0] M_AXIS_TDATA,
    output logic [C_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,
    input  logic                                enable,
    input  logic [15:0]                         pkt_words,
    input  logic                                seq_clr,
    output logic                                busy,
    output logic [31:0]                         seq
);
    localparam int W  = 8 * C_AXIS_TDATA_NUM_BYTES;
    localparam int NB = C_AXIS_TDATA_NUM_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_DATA  = 2'd2
`ifdef ADI2AXIS_PKT_TRAILER_EN
        , ST_TRAIL = 2'd3
`endif
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_tvalid;
    logic            r_tlast;
    logic [W-1:0]    r_tdata;
    logic [NB-1:0]   r_tstrb;
    logic [15:0]     r_plen;
    logic [15:0]     r_cnt;
    logic [31:0]     r_seq;
    logic            r_soc;
`ifdef ADI2AXIS_PKT_TRAILER_EN
    logic [31:0]     r_hdr_seq;
    logic            r_end_tlast;
`endif

    logic            w_slot_free;
    logic            w_accept;
    logic            w_last;
    logic            w_load;
    logic            w_load_last;
    logic            w_hdr_load;
    logic [W-1:0]    w_load_data;
    logic [NB-1:0]   w_load_strb;
    logic [15:0]     w_plen_new;
    logic [31:0]     w_hdr_seq;

    // The output slot can take a new beat when it is empty or is being drained this cycle.
    assign w_slot_free = !r_tvalid || M_AXIS_TREADY;
    assign w_plen_new  = (pkt_words == 16'd0) ? 16'd1 : pkt_words;
    // A clear that lands on the same cycle as a header load wins that header.
    assign w_hdr_seq   = seq_clr ? 32'd0 : r_seq;
    assign w_accept    = (r_state == ST_DATA) && w_slot_free && S_AXIS_TVALID;
    assign w_last      = w_accept && ((r_cnt == r_plen - 16'd1) || S_AXIS_TLAST);

    assign S_AXIS_TREADY = (r_state == ST_DATA) && w_slot_free;
    assign M_AXIS_TVALID = r_tvalid;
    assign M_AXIS_TDATA  = r_tdata;
    assign M_AXIS_TSTRB  = r_tstrb;
    assign M_AXIS_TLAST  = r_tlast;
    assign busy          = (r_state != ST_IDLE);
    assign seq           = r_seq;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_data  = '0;
        w_load_strb  = '0;
        w_load_last  = 1'b0;
        w_hdr_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && S_AXIS_TVALID) begin
                    w_state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_slot_free) begin
                    w_hdr_load          = 1'b1;
                    w_load              = 1'b1;
                    w_load_data[63:48]  = 16'hADC0;
                    w_load_data[47]     = r_soc;
                    w_load_data[46:32]  = w_plen_new[14:0];
                    w_load_data[31:0]   = w_hdr_seq;
                    w_load_strb         = '1;
                    w_state_next        = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_load_data = S_AXIS_TDATA;
                    w_load_strb = S_AXIS_TSTRB;
`ifdef ADI2AXIS_PKT_TRAILER_EN
                    if (w_last) begin
                        w_state_next = ST_TRAIL;
                    end
`else
                    w_load_last = w_last;
                    if (w_last) begin
                        w_state_next = ST_IDLE;
                    end
`endif
                end
            end
`ifdef ADI2AXIS_PKT_TRAILER_EN
            ST_TRAIL: begin
                if (w_slot_free) begin
                    w_load              = 1'b1;
                    w_load_data[63:48]  = 16'hADCF;
                    w_load_data[47]     = r_end_tlast;
                    // r_cnt already counts the last beat here.
                    w_load_data[46:32]  = r_cnt[14:0];
                    w_load_data[31:0]   = r_hdr_seq;
                    w_load_strb         = '1;
                    w_load_last         = 1'b1;
                    w_state_next        = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            r_state  <= ST_IDLE;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_tstrb  <= '0;
            r_plen   <= 16'd1;
            r_cnt    <= 16'd0;
            r_seq    <= 32'd0;
            r_soc    <= 1'b1;
`ifdef ADI2AXIS_PKT_TRAILER_EN
            r_hdr_seq   <= 32'd0;
            r_end_tlast <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;

            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_load_data;
                r_tstrb  <= w_load_strb;
                r_tlast  <= w_load_last;
            end else if (w_slot_free) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end

            if (w_hdr_load) begin
                r_plen <= w_plen_new;
                r_cnt  <= 16'd0;
                r_seq  <= w_hdr_seq + 32'd1;
                r_soc  <= 1'b0;
`ifdef ADI2AXIS_PKT_TRAILER_EN
                r_hdr_seq <= w_hdr_seq;
`endif
            end else if (seq_clr) begin
                r_seq <= 32'd0;
            end

            if (w_accept) begin
                r_cnt <= r_cnt + 16'd1;
                // A capture boundary marks the next header as start-of-capture.
                if (w_last && S_AXIS_TLAST) begin
                    r_soc <= 1'b1;
                end
`ifdef ADI2AXIS_PKT_TRAILER_EN
                if (w_last) begin
                    r_end_tlast <= S_AXIS_TLAST;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_adi2axis_pkt.sv
// -----------------------------------------------------------------------------
// tb_adi2axis_pkt
// Randomized bench for adi2axis_pkt. Every capture that is queued for the
// input is also expanded by a stream-level model into the packet sequence it
// must produce. That sequence is: header, payload chunks, and TLAST positions.
// A monitor process compares each output handshake against that sequence.
// It also checks that the output holds steady while it is stalled.
// A few hand-computed headers pin the model to known values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adi2axis_pkt;
    localparam int NB = 8;
    localparam int W  = 8 * NB;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [NB-1:0] strb;
        logic          last;
    } beat_t;

    logic          AXIS_ACLK = 1'b0;
    logic          AXIS_ARESETN = 1'b0;
    logic          S_AXIS_TVALID = 1'b0;
    logic [W-1:0]  S_AXIS_TDATA = '0;
    logic [NB-1:0] S_AXIS_TSTRB = '0;
    logic          S_AXIS_TLAST = 1'b0;
    logic          S_AXIS_TREADY;
    logic          M_AXIS_TVALID;
    logic [W-1:0]  M_AXIS_TDATA;
    logic [NB-1:0] M_AXIS_TSTRB;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TREADY = 1'b1;
    logic          enable = 1'b0;
    logic [15:0]   pkt_words = 16'd4;
    logic          seq_clr = 1'b0;
    logic          busy;
    logic [31:0]   seq;

    adi2axis_pkt #(.C_AXIS_TDATA_NUM_BYTES(NB)) dut (
        .AXIS_ACLK     (AXIS_ACLK),
        .AXIS_ARESETN  (AXIS_ARESETN),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TSTRB  (S_AXIS_TSTRB),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .enable        (enable),
        .pkt_words     (pkt_words),
        .seq_clr       (seq_clr),
        .busy          (busy),
        .seq           (seq)
    );

    always #5 AXIS_ACLK = ~AXIS_ACLK;

    int    n_cmp = 0;
    int    n_fail = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    beat_t log_q[$];
    int    beat_no = 0;
    bit    mon_en = 1'b0;
    bit    rdy_rand = 1'b0;
    int    gap_pct = 0;
    logic [31:0] m_seq = 32'd0;
    bit          m_soc = 1'b1;

    // Model: split an n-word capture into packets of plen words.
    // Queue the input beats for the driver and the expected output beats.
    task automatic push_capture(input int n, input int pw);
        int    plen;
        int    done;
        int    chunk;
        beat_t h;
        beat_t b;
        plen = (pw == 0) ? 1 : pw;
        done = 0;
        while (done < n) begin
            chunk = (n - done < plen) ? (n - done) : plen;
            h = '0;
            h.data[63:48] = 16'hADC0;
            h.data[47]    = m_soc;
            h.data[46:32] = plen[14:0];
            h.data[31:0]  = m_seq;
            h.strb        = '1;
            exp_q.push_back(h);
            m_seq = m_seq + 32'd1;
            m_soc = 1'b0;
            for (int k = 0; k < chunk; k++) begin
                b.data = {$urandom, $urandom};
                b.strb = NB'($urandom);
                b.last = (done + k == n - 1);
                in_q.push_back(b);
                b.last = (k == chunk - 1);
                exp_q.push_back(b);
            end
            done += chunk;
        end
        m_soc = 1'b1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic wait_drain(input int max_cyc, input string tag);
        int c;
        c = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0 || busy) && c < max_cyc) begin
            @(posedge AXIS_ACLK);
            c++;
        end
        repeat (3) @(posedge AXIS_ACLK);
        #1;
        n_cmp++;
        if (c >= max_cyc) begin
            n_fail++;
            $display("FAIL drain_%s: timeout with %0d in, %0d expected beats left, busy=%b",
                     tag, in_q.size(), exp_q.size(), busy);
        end
    endtask

    task automatic wait_busy(input string tag);
        int c;
        c = 0;
        @(posedge AXIS_ACLK);
        #1;
        while (!busy && c < 50) begin
            @(posedge AXIS_ACLK);
            #1;
            c++;
        end
        if (c >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL busy_%s: busy stayed %b, required 1", tag, busy);
        end
    endtask

    // Input driver. It presents in_q beats and keeps TVALID and its data
    // stable until the beat is accepted.
    initial begin : drv
        bit hs;
        forever begin
            @(negedge AXIS_ACLK);
            hs = S_AXIS_TVALID && S_AXIS_TREADY && AXIS_ARESETN;
            @(posedge AXIS_ACLK);
            #1;
            if (hs && in_q.size() > 0) begin
                void'(in_q.pop_front());
            end
            if (in_q.size() > 0 && ((S_AXIS_TVALID && !hs) || $urandom_range(99) >= gap_pct)) begin
                S_AXIS_TVALID = 1'b1;
                S_AXIS_TDATA  = in_q[0].data;
                S_AXIS_TSTRB  = in_q[0].strb;
                S_AXIS_TLAST  = in_q[0].last;
            end else begin
                S_AXIS_TVALID = 1'b0;
                S_AXIS_TDATA  = '0;
                S_AXIS_TSTRB  = '0;
                S_AXIS_TLAST  = 1'b0;
            end
        end
    end

    initial begin : rdy_drv
        forever begin
            @(posedge AXIS_ACLK);
            #1;
            M_AXIS_TREADY = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Compare process. It checks each output handshake and the hold-while-stalled rule.
    initial begin : mon
        beat_t g;
        beat_t p;
        beat_t e;
        bit    stall_prev;
        stall_prev = 1'b0;
        p = '0;
        forever begin
            @(negedge AXIS_ACLK);
            if (!mon_en || !AXIS_ARESETN) begin
                stall_prev = 1'b0;
            end else begin
                g = {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST};
                if (stall_prev) begin
                    n_cmp++;
                    if (!M_AXIS_TVALID || g !== p) begin
                        n_fail++;
                        $display("FAIL hold: got valid=%b %h/%h/%b required 1 %h/%h/%b",
                                 M_AXIS_TVALID, g.data, g.strb, g.last, p.data, p.strb, p.last);
                    end
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    log_q.push_back(g);
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL beat %0d: unexpected beat %h last=%b", beat_no, g.data, g.last);
                    end else begin
                        e = exp_q.pop_front();
                        if (g !== e) begin
                            n_fail++;
                            $display("FAIL beat %0d: got %h/%h/%b expected %h/%h/%b",
                                     beat_no, g.data, g.strb, g.last, e.data, e.strb, e.last);
                        end else begin
                            $display("beat %0d: data=%h strb=%h last=%b ok", beat_no, g.data, g.strb, g.last);
                        end
                    end
                    beat_no++;
                end
                stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
                p = g;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int total;
        int n;
        repeat (3) @(posedge AXIS_ACLK);
        @(negedge AXIS_ACLK);
        check("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("rst_tready", 64'(S_AXIS_TREADY), 64'd0);
        check("rst_tdata",  M_AXIS_TDATA, 64'd0);
        check("rst_tstrb",  64'(M_AXIS_TSTRB), 64'd0);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_seq",    64'(seq), 64'd0);
        @(posedge AXIS_ACLK);
        #1;
        AXIS_ARESETN = 1'b1;
        enable = 1'b1;
        mon_en = 1'b1;

        // Two full packets from one 8-word capture.
        log_q.delete();
        push_capture(8, 4);
        wait_drain(200, "t1");
        check("t1_hdr0", log_q[0].data, 64'hADC0_8004_0000_0000);
        check("t1_hdr1", log_q[5].data, 64'hADC0_0004_0000_0001);
        check("t1_last5", 64'(log_q[4].last), 64'd1);
        check("t1_last10", 64'(log_q[9].last), 64'd1);
        check("t1_seq", 64'(seq), 64'd2);

        // A short second packet, then the next capture starts with soc set.
        log_q.delete();
        push_capture(6, 4);
        push_capture(3, 4);
        wait_drain(200, "t2");
        check("t2_hdr2_len", 64'(log_q[5].data[46:32]), 64'd4);
        check("t2_short_last", 64'(log_q[7].last), 64'd1);
        check("t2_soc", 64'(log_q[8].data[47]), 64'd1);

        // pkt_words=0 behaves as one word per packet.
        pkt_words = 16'd0;
        log_q.delete();
        push_capture(3, 0);
        wait_drain(200, "t3");
        check("t3_len0", 64'(log_q[0].data[46:32]), 64'd1);
        check("t3_len2", 64'(log_q[4].data[46:32]), 64'd1);
        check("t3_last", 64'(log_q[1].last), 64'd1);

        // A pkt_words change after the header is loaded does not affect the current packet.
        pkt_words = 16'd4;
        log_q.delete();
        push_capture(3, 4);
        wait_busy("t3b");
        repeat (2) @(posedge AXIS_ACLK);
        #1;
        pkt_words = 16'd0;
        wait_drain(200, "t3b");
        check("t3b_len", 64'(log_q[0].data[46:32]), 64'd4);
        pkt_words = 16'd4;

        // seq_clr in the same cycle as a header load.
        log_q.delete();
        m_seq = 32'd0;
        push_capture(2, 4);
        wait_busy("t4");
        seq_clr = 1'b1;
        @(posedge AXIS_ACLK);
        #1;
        seq_clr = 1'b0;
        wait_drain(200, "t4");
        check("t4_hdr_seq", 64'(log_q[0].data[31:0]), 64'd0);
        check("t4_seq", 64'(seq), 64'd1);

        // seq_clr while idle.
        seq_clr = 1'b1;
        @(posedge AXIS_ACLK);
        #1;
        seq_clr = 1'b0;
        m_seq = 32'd0;
        @(negedge AXIS_ACLK);
        check("t4_clr_idle", 64'(seq), 64'd0);

        // Wrap of the sequence counter, preset through a backdoor.
        @(posedge AXIS_ACLK);
        #1;
        force dut.r_seq = 32'hFFFF_FFFF;
        @(posedge AXIS_ACLK);
        #1;
        release dut.r_seq;
        @(negedge AXIS_ACLK);
        if (seq === 32'hFFFF_FFFF) begin
            m_seq = 32'hFFFF_FFFF;
            pkt_words = 16'd1;
            log_q.delete();
            push_capture(2, 1);
            wait_drain(200, "t4w");
            check("t4w_hdr_max", 64'(log_q[0].data[31:0]), 64'hFFFF_FFFF);
            check("t4w_hdr_wrap", 64'(log_q[2].data[31:0]), 64'd0);
            check("t4w_seq", 64'(seq), 64'd1);
        end else begin
            $display("note: seq backdoor not available, wrap case skipped");
        end
        @(posedge AXIS_ACLK);
        #1;
        seq_clr = 1'b1;
        @(posedge AXIS_ACLK);
        #1;
        seq_clr = 1'b0;
        m_seq = 32'd0;

        // Drop enable mid-packet. The current packet completes and no new header follows.
        pkt_words = 16'd5;
        push_capture(12, 5);
        wait_busy("t5");
        repeat (2) @(posedge AXIS_ACLK);
        #1;
        enable = 1'b0;
        repeat (15) @(posedge AXIS_ACLK);
        @(negedge AXIS_ACLK);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_tready", 64'(S_AXIS_TREADY), 64'd0);
        check("t5_pending", 64'(exp_q.size()), 64'd9);
        @(posedge AXIS_ACLK);
        #1;
        enable = 1'b1;
        wait_drain(200, "t5");

        // Random back-pressure and input gaps over 1000 words.
        pkt_words = 16'd7;
        rdy_rand = 1'b1;
        gap_pct = 20;
        total = 0;
        while (total < 1000) begin
            n = $urandom_range(1, 120);
            if (total + n > 1000) n = 1000 - total;
            push_capture(n, 7);
            total += n;
        end
        wait_drain(20000, "t6");
        rdy_rand = 1'b0;
        gap_pct = 0;

        // Reset mid-packet.
        pkt_words = 16'd4;
        push_capture(10, 4);
        wait_busy("t7");
        repeat (3) @(posedge AXIS_ACLK);
        #1;
        mon_en = 1'b0;
        AXIS_ARESETN = 1'b0;
        in_q.delete();
        exp_q.delete();
        @(posedge AXIS_ACLK);
        @(negedge AXIS_ACLK);
        check("t7_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("t7_tlast",  64'(M_AXIS_TLAST), 64'd0);
        check("t7_tdata",  M_AXIS_TDATA, 64'd0);
        check("t7_tstrb",  64'(M_AXIS_TSTRB), 64'd0);
        check("t7_tready", 64'(S_AXIS_TREADY), 64'd0);
        check("t7_busy",   64'(busy), 64'd0);
        check("t7_seq",    64'(seq), 64'd0);
        @(posedge AXIS_ACLK);
        #1;
        AXIS_ARESETN = 1'b1;
        m_seq = 32'd0;
        m_soc = 1'b1;
        mon_en = 1'b1;
        pkt_words = 16'd3;
        log_q.delete();
        push_capture(2, 3);
        wait_drain(200, "t7r");
        check("t7_recover_hdr", log_q[0].data, 64'hADC0_8003_0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
